clint_access_engine: RTL
========================

Name: clint_access_engine

Overview:
- Bus initiator that drives the CLINT memory-mapped slave port: mem_req/we/addr/wdata/be out, rdata/ready in.
- Turns single 64-bit commands (read mtime, read/write mtimecmp, write msip) into correctly ordered 32-bit beat sequences. Reads of mtime are tear-free; writes of mtimecmp raise no spurious interrupt.
- Sits between a boot/debug/hart-management agent and the CLINT in riscv_soc_top.

Parameters:
- NUM_CORES, DEFAULT_CORE_CONFIG.num_cores, number of harts addressable.
- CLINT_BASE, 32'h0200_0000, CLINT base address.
- MSIP_OFFSET, 32'h0000_0000, msip array offset, stride 4.
- MTIMECMP_OFFSET, 32'h0000_4000, mtimecmp array offset, stride 8.
- MTIME_OFFSET, 32'h0000_BFF8, mtime offset.
- TIMEOUT_CYCLES, 16, cycles a beat may wait for mem_ready_i before abort.
- MAX_RETRY, 3, mtime hi-mismatch retries before error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  clint_op_e: 0 RD_MTIME, 1 WR_MTIMECMP, 2 WR_MSIP, 3 RD_MTIMECMP
- cmd_hart_i  in  5  target hart index
- cmd_wdata_i  in  64  write data (WR_MSIP uses bit 0)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  64  read result (0 for writes and on abort)
- rsp_err_o  out  1  bad hart, timeout, or retry exhaustion
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables, always 4'hF
- mem_rdata_i  in  32  read data, valid when mem_req_o&mem_ready_i
- mem_ready_i  in  1  beat complete (may be combinational on req)

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1. FSM to IDLE. Counters and captured data cleared. Reset mid-sequence abandons the command with no response.
- FSM IDLE -> ISSUE -> RESP -> IDLE. cmd_ready_o=(state==IDLE). The command is registered on handshake.
- cmd_hart_i>=NUM_CORES (RD_MTIME exempt): IDLE->RESP directly, err=1, no bus traffic.
- ISSUE: mem_req_o=1 with addr/we/wdata stable until the cycle mem_ready_i=1. A beat completes on that edge. The next beat is presented on the following cycle, so req may stay high back-to-back.
- Beat sequences (A=CLINT_BASE+offset, 32-bit wrap arithmetic):
  - WR_MSIP: write A=MSIP_OFFSET+4*hart, data {31'b0,wdata[0]}.
  - WR_MTIMECMP: M=MTIMECMP_OFFSET+8*hart. Write M <- 32'hFFFF_FFFF. Write M+4 <- wdata[63:32]. Write M <- wdata[31:0].
  - RD_MTIMECMP: read M -> lo, then read M+4 -> hi.
  - RD_MTIME: read MTIME+4 -> h1, read MTIME -> lo, read MTIME+4 -> h2.
    - If h2==h1: result {h1,lo}.
    - Else retry++. If retry<=MAX_RETRY, set h1=h2 and restart at the lo read. Otherwise err=1, result {h2,lo}.
- Timeout: a counter runs while mem_req_o&!mem_ready_i and resets on each completed beat. Reaching TIMEOUT_CYCLES aborts: mem_req_o drops the next cycle, RESP with err=1, rdata=0.
- Latency with zero-wait slave: accept at edge T, first req cycle T+1, one cycle per beat, rsp_valid_o rises the cycle after the last beat. WR_MSIP gives rsp_valid_o at T+2.
- RESP: rsp_valid_o held with stable data until rsp_ready_i. It clears on that edge, returning to IDLE; a new command can be accepted the following cycle.
- mem_we_o, mem_addr_o, mem_wdata_o are 0 whenever mem_req_o=0.

Decomposition:
- riscv_clint_pkg holds:
  - clint_op_e enum.
  - CLINT offset/stride constants, shared with clint defaults.
  - Beat descriptor struct {we, addr, wdata}.
- Sub-module clint_bus_beat: single-beat master holding req until ready, with timeout counter. It exposes start/done/timeout/rdata. The engine sequences beats through it.

Test Plan:
- WR_MSIP hart1 wdata=1, zero-wait slave -> one write to 0x0200_0004 data 0x1, be F; rsp_valid at T+2, err=0, rdata=0.
- WR_MTIMECMP hart0 wdata=0x0000_0001_2345_6789 -> writes in order: 0x0200_4000<-FFFF_FFFF, 0x0200_4004<-0000_0001, 0x0200_4000<-2345_6789; err=0.
- RD_MTIME with rollover: hi=5, lo=FFFF_FFFF, hi=6, lo=2, hi=6 -> rdata 0x0000_0006_0000_0002, err=0, 5 beats total.
- cmd_hart_i=NUM_CORES, op WR_MSIP -> mem_req_o never asserted; rsp err=1 on cycle after accept.
- Slave never readies on RD_MTIMECMP -> req held exactly 16 cycles, then dropped; rsp err=1, rdata=0. Also hold rsp_ready_i=0 for 5 cycles -> rsp stable, cmd_ready_o=0.
- Assert rst_ni mid RD_MTIME (after 2nd beat) -> mem_req_o=0 and rsp_valid_o=0 immediately; cmd_ready_o=1 after release; next WR_MSIP completes normally.

Source files
------------

// File: rtl/riscv_clint_pkg.sv
// Shared CLINT types and address map used by the access engine and its beat master.
package riscv_clint_pkg;

  typedef struct packed {
    logic [31:0] num_cores;
  } core_config_t;

  localparam core_config_t DEFAULT_CORE_CONFIG = '{num_cores: 32'd4};

  localparam logic [31:0] CLINT_BASE_ADDR     = 32'h0200_0000;
  localparam logic [31:0] CLINT_MSIP_OFS      = 32'h0000_0000;
  localparam logic [31:0] CLINT_MSIP_STRIDE   = 32'd4;
  localparam logic [31:0] CLINT_MTIMECMP_OFS  = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_STRD = 32'd8;
  localparam logic [31:0] CLINT_MTIME_OFS     = 32'h0000_BFF8;

  typedef enum logic [1:0] {
    OP_RD_MTIME    = 2'd0,
    OP_WR_MTIMECMP = 2'd1,
    OP_WR_MSIP     = 2'd2,
    OP_RD_MTIMECMP = 2'd3
  } clint_op_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_desc_t;

  // Index of the final beat for the fixed-length sequences (RD_MTIME may loop back).
  function automatic logic [1:0] last_beat_idx(clint_op_e op);
    case (op)
      OP_WR_MSIP:     return 2'd0;
      OP_RD_MTIMECMP: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/clint_access_engine_if.sv
// 32-bit memory-mapped bus between the access engine (master) and the CLINT slave port.
interface clint_access_engine_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, be, input rdata, ready);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready);
endinterface

// File: rtl/clint_bus_beat.sv
// Single-beat bus master: holds a request stable until the slave is ready or the wait budget expires.
module clint_bus_beat
  import riscv_clint_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  beat_desc_t  desc_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  clint_access_engine_if.master mem
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          req_reg;
  beat_desc_t    desc_reg;
  logic [CW-1:0] wait_cnt_reg;

  assign done_o    = req_reg & mem.ready;
  assign timeout_o = req_reg & ~mem.ready & (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  // A start in the same cycle as a completion keeps req high for back-to-back beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_reg      <= 1'b0;
      desc_reg     <= '0;
      wait_cnt_reg <= '0;
    end else if (start_i) begin
      req_reg      <= 1'b1;
      desc_reg     <= desc_i;
      wait_cnt_reg <= '0;
    end else if (done_o || timeout_o) begin
      req_reg      <= 1'b0;
      wait_cnt_reg <= '0;
    end else if (req_reg) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign mem.req   = req_reg;
  assign mem.we    = req_reg & desc_reg.we;
  assign mem.addr  = req_reg ? desc_reg.addr  : 32'h0;
  assign mem.wdata = req_reg ? desc_reg.wdata : 32'h0;
  assign mem.be    = req_reg ? 4'hF : 4'h0;
  assign rdata_o   = mem.rdata;

endmodule

// File: rtl/clint_access_engine.sv
// Turns 64-bit CLINT commands into ordered 32-bit beats: tear-free mtime reads, glitch-free mtimecmp writes.
module clint_access_engine
  import riscv_clint_pkg::*;
#(
  parameter int unsigned NUM_CORES       = DEFAULT_CORE_CONFIG.num_cores,
  parameter logic [31:0] CLINT_BASE      = CLINT_BASE_ADDR,
  parameter logic [31:0] MSIP_OFFSET     = CLINT_MSIP_OFS,
  parameter logic [31:0] MTIMECMP_OFFSET = CLINT_MTIMECMP_OFS,
  parameter logic [31:0] MTIME_OFFSET    = CLINT_MTIME_OFS,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_hart_i,
  input  logic [63:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  clint_access_engine_if.master mem
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e        state_reg, state_next;
  clint_op_e     op_reg, op_next;
  logic [4:0]    hart_reg, hart_next;
  logic [63:0]   wdata_reg, wdata_next;
  logic [1:0]    idx_reg, idx_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [31:0]   h1_reg, h1_next, lo_reg, lo_next;
  logic [63:0]   result_reg, result_next;
  logic          err_reg, err_next;

  logic        beat_start, beat_done, beat_timeout;
  logic [31:0] beat_rdata;
  beat_desc_t  beat_desc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= S_IDLE;
      op_reg     <= OP_RD_MTIME;
      hart_reg   <= '0;
      wdata_reg  <= '0;
      idx_reg    <= '0;
      retry_reg  <= '0;
      h1_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      hart_reg   <= hart_next;
      wdata_reg  <= wdata_next;
      idx_reg    <= idx_next;
      retry_reg  <= retry_next;
      h1_reg     <= h1_next;
      lo_reg     <= lo_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    hart_next   = hart_reg;
    wdata_next  = wdata_reg;
    idx_next    = idx_reg;
    retry_next  = retry_reg;
    h1_next     = h1_reg;
    lo_next     = lo_reg;
    result_next = result_reg;
    err_next    = err_reg;
    beat_start  = 1'b0;
    unique case (state_reg)
      S_IDLE: if (cmd_valid_i) begin
        op_next     = clint_op_e'(cmd_op_i);
        hart_next   = cmd_hart_i;
        wdata_next  = cmd_wdata_i;
        idx_next    = '0;
        retry_next  = '0;
        h1_next     = '0;
        lo_next     = '0;
        result_next = '0;
        err_next    = 1'b0;
        // mtime is global, so the hart index only matters for per-hart registers.
        if (op_next != OP_RD_MTIME && 32'(cmd_hart_i) >= NUM_CORES) begin
          err_next   = 1'b1;
          state_next = S_RESP;
        end else begin
          beat_start = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: if (beat_timeout) begin
        err_next    = 1'b1;
        result_next = '0;
        state_next  = S_RESP;
      end else if (beat_done) begin
        unique case (op_reg)
          OP_RD_MTIME: begin
            if (idx_reg == 2'd0) begin
              h1_next = beat_rdata; idx_next = 2'd1; beat_start = 1'b1;
            end else if (idx_reg == 2'd1) begin
              lo_next = beat_rdata; idx_next = 2'd2; beat_start = 1'b1;
            end else if (beat_rdata == h1_reg) begin
              result_next = {h1_reg, lo_reg};
              state_next  = S_RESP;
            end else begin
              // hi moved under us: lo may belong to either epoch, so re-read it.
              retry_next = retry_reg + RW'(1);
              if (retry_reg < RW'(MAX_RETRY)) begin
                h1_next = beat_rdata; idx_next = 2'd1; beat_start = 1'b1;
              end else begin
                err_next    = 1'b1;
                result_next = {beat_rdata, lo_reg};
                state_next  = S_RESP;
              end
            end
          end
          OP_RD_MTIMECMP: begin
            if (idx_reg == 2'd0) begin
              lo_next = beat_rdata; idx_next = 2'd1; beat_start = 1'b1;
            end else begin
              result_next = {beat_rdata, lo_reg};
              state_next  = S_RESP;
            end
          end
          default: begin
            if (idx_reg == last_beat_idx(op_reg)) begin
              state_next = S_RESP;
            end else begin
              idx_next = idx_reg + 2'd1; beat_start = 1'b1;
            end
          end
        endcase
      end
      S_RESP: if (rsp_ready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  logic [31:0] msip_addr, cmp_addr, mtime_addr;

  assign msip_addr  = CLINT_BASE + MSIP_OFFSET + 32'(hart_next) * CLINT_MSIP_STRIDE;
  assign cmp_addr   = CLINT_BASE + MTIMECMP_OFFSET + 32'(hart_next) * CLINT_MTIMECMP_STRD;
  assign mtime_addr = CLINT_BASE + MTIME_OFFSET;

  // Parking mtimecmp at all-ones first keeps it above mtime while the halves change.
  always_comb begin
    beat_desc = '0;
    unique case (op_next)
      OP_WR_MSIP: beat_desc = '{we: 1'b1, addr: msip_addr, wdata: {31'b0, wdata_next[0]}};
      OP_WR_MTIMECMP: begin
        if (idx_next == 2'd0)      beat_desc = '{we: 1'b1, addr: cmp_addr, wdata: 32'hFFFF_FFFF};
        else if (idx_next == 2'd1) beat_desc = '{we: 1'b1, addr: cmp_addr + 32'd4, wdata: wdata_next[63:32]};
        else                       beat_desc = '{we: 1'b1, addr: cmp_addr, wdata: wdata_next[31:0]};
      end
      OP_RD_MTIMECMP: beat_desc.addr = (idx_next == 2'd0) ? cmp_addr : cmp_addr + 32'd4;
      default:        beat_desc.addr = (idx_next == 2'd1) ? mtime_addr : mtime_addr + 32'd4;
    endcase
  end

  clint_bus_beat #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_beat (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (beat_start),
    .desc_i   (beat_desc),
    .done_o   (beat_done),
    .timeout_o(beat_timeout),
    .rdata_o  (beat_rdata),
    .mem      (mem)
  );

  assign cmd_ready_o = (state_reg == S_IDLE);
  assign rsp_valid_o = (state_reg == S_RESP);
  assign rsp_rdata_o = rsp_valid_o ? result_reg : 64'h0;
  assign rsp_err_o   = rsp_valid_o & err_reg;

endmodule
